cprs_err_recover: RTL and testbench
===================================

// Module: cprs_err_recover
// PURPOSE
//  Receiving end of an approximate 4:2 compressor row. Takes per-column (sum, carry, err) vectors
//  at column weight 2^i and reconstructs the exact binary value by adding back the err-flagged shortfall.
//  Two-stage valid/ready pipeline between the compressor tree and the final multiplier/accumulator stage.
//  An err flag marks a column whose four inputs were all 1: exact count 4, approximate output 0.
// PARAMETERS
//  W         8  number of compressor columns (bits per input vector)
//  ERR_CORR  4  per-column value restored when err_i=1 (weight ERR_CORR*2^i)
// PORTS
//  clk        in   1      clock
//  rst        in   1      synchronous active-high reset
//  in_valid   in   1      input vectors valid
//  in_ready   out  1      block accepts input this cycle
//  in_sum     in   W      column sum bits, bit i weight 2^i
//  in_carry   in   W      column carry bits, bit i weight 2^(i+1)
//  in_err     in   W      column error flags, bit i weight ERR_CORR*2^i
//  corr_en    in   1      1=apply correction; 0=pass approximate value (sampled with the input beat)
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  out_res    out  W+3    reconstructed value
//  out_errcnt out  CW     popcount(in_err) of this beat, CW=$clog2(W+1)
// BEHAVIOUR
//  - One clock, synchronous active-high reset. Reset clears both stage valids, out_valid=0,
//    out_res=0, out_errcnt=0, statistics=0. in_ready=1 in the cycle after reset deasserts.
//  - Transfer on valid&ready on each side. Latency: accepted beat is presented 2 cycles later if unstalled.
//  - S1 (register): a = in_sum + (in_carry<<1); e = corr_en ? in_err*ERR_CORR : 0; errcnt = popcount(in_err).
//  - S2 (register): out_res = a + e; out_errcnt forwarded. All arithmetic W+3 bits, zero-extended,
//    cannot overflow (max 7*(2^W-1) < 2^(W+3)).
//  - Stage advance rule: stage k loads when its own valid is 0 or the next stage loads/drains this cycle.
//    in_ready = !s1_valid | s2_load; s2_load = s1_valid & (!out_valid | out_ready).
//  - Full throughput: one beat per cycle while out_ready=1. No bubbles on simultaneous accept and drain.
//  - Stall: while out_valid & !out_ready, out_res/out_errcnt hold stable.
//    S1 holds; in_ready=0 once S1 is full.
//  - corr_en travels with its beat; changing corr_en mid-stream never affects beats already accepted.
//  - Reset mid-operation drops all in-flight beats; no partial output.
//  - in_err bit set with in_sum/in_carry bit also set is legal; it is summed arithmetically as given.
// CONFIGURATION
//  `CPRS_ERR_STAT_EN defined: adds ports stat_beats (out, 32) and stat_errs (out, 32).
//    They are saturating counters of accepted output beats and summed out_errcnt.
//    They update on out_valid&out_ready, clear on rst, and saturate at 2^32-1.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  cprs_pkg: ERR_CORR_DEFAULT=4, function clog2, typedef for stage-1 payload struct (a, e, errcnt).
//  Sub-module cprs_popcount (W-bit popcount, combinational) instantiated in S1; all else in top.
// TESTING (W=8)
//  1 sum=8'hFF carry=0 err=0 corr_en=1 -> out_res=255, errcnt=0, 2 cycles after accept.
//  2 sum=0 carry=0 err=8'hFF corr_en=1 -> out_res=1020; same beat with corr_en=0 -> out_res=0, errcnt=8.
//  3 sum=8'hFF carry=8'hFF err=8'hFF corr_en=1 -> out_res=1785 (max value, no overflow).
//  4 Back-to-back 16 random beats, out_ready=1 -> one result/cycle, in order, matching the model.
//  5 out_ready held 0 for 5 cycles with 3 beats offered -> 2 held in pipe, in_ready=0.
//    out_res stable; release -> all 3 delivered in order, no loss or duplicate.
//  6 rst pulsed with 2 beats in flight -> out_valid=0 next cycle, no stale output.
//    With CPRS_ERR_STAT_EN, stat counters=0.

Source files
------------

// File: rtl/cprs_pkg.sv
// Shared types and helpers for the approximate 4:2 compressor
// error-recovery pipeline.
package cprs_pkg;

  localparam int ERR_CORR_DEFAULT = 4;

  // Largest column count the stage-1 payload can carry.
  localparam int CPRS_MAX_W  = 32;
  localparam int CPRS_MAX_CW = 6;
  localparam int CPRS_PW     = CPRS_MAX_W + 3;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Stage-1 payload: partial sum, correction term and error count.
  typedef struct packed {
    logic [CPRS_PW-1:0]     a;
    logic [CPRS_PW-1:0]     e;
    logic [CPRS_MAX_CW-1:0] errcnt;
  } s1_pay_t;

endpackage

// File: rtl/cprs_popcount.sv
// W-bit combinational population count, used to count the
// err-flagged columns of an input beat.
module cprs_popcount #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic [W-1:0]  vec_i,
  output logic [CW-1:0] cnt_o
);

  // Ripple-add each flag bit into the count.
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) begin
      cnt_o = cnt_o + CW'(vec_i[i]);
    end
  end

endmodule

// File: rtl/cprs_err_recover.sv
// Two-stage valid/ready pipeline that rebuilds the exact value of
// an approximate 4:2 compressor row. Optional stats: CPRS_ERR_STAT_EN.
module cprs_err_recover
  import cprs_pkg::*;
#(
  parameter int W        = 8,
  parameter int ERR_CORR = ERR_CORR_DEFAULT,
  localparam int CW      = clog2(W + 1),
  localparam int RW      = W + 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_sum,
  input  logic [W-1:0]  in_carry,
  input  logic [W-1:0]  in_err,
  input  logic          corr_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_res,
  output logic [CW-1:0] out_errcnt
`ifdef CPRS_ERR_STAT_EN
  ,
  output logic [31:0]   stat_beats,
  output logic [31:0]   stat_errs
`endif
);

  logic          s1_v_q;
  logic          s1_v_d;
  s1_pay_t       s1_q;
  s1_pay_t       s1_d;
  logic          ov_q;
  logic          ov_d;
  logic [RW-1:0] res_q;
  logic [RW-1:0] res_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic          s1_load;
  logic          s2_load;
  logic [RW-1:0] a_w;
  logic [RW-1:0] e_w;
  logic [CW-1:0] pc_w;

  // S2 takes the S1 beat when the output is empty or draining;
  // S1 takes a new beat when empty or when S2 takes its beat.
  assign s2_load  = s1_v_q & (~ov_q | out_ready);
  assign in_ready = ~s1_v_q | s2_load;
  assign s1_load  = in_valid & in_ready;

  cprs_popcount #(
    .W  (W),
    .CW (CW)
  ) u_popcount (
    .vec_i (in_err),
    .cnt_o (pc_w)
  );

  // Stage-1 next state: carry-weighted sum and gated correction.
  always_comb begin
    a_w    = RW'(in_sum) + (RW'(in_carry) << 1);
    e_w    = corr_en ? (RW'(in_err) * RW'(ERR_CORR)) : '0;
    s1_v_d = in_ready ? in_valid : s1_v_q;
    s1_d   = s1_q;
    if (s1_load) begin
      s1_d.a      = CPRS_PW'(a_w);
      s1_d.e      = CPRS_PW'(e_w);
      s1_d.errcnt = CPRS_MAX_CW'(pc_w);
    end
  end

  // Stage-2 next state: final add; hold while stalled.
  always_comb begin
    res_d = res_q;
    cnt_d = cnt_q;
    ov_d  = ov_q;
    if (s2_load) begin
      res_d = RW'(s1_q.a + s1_q.e);
      cnt_d = CW'(s1_q.errcnt);
      ov_d  = 1'b1;
    end else if (out_ready) begin
      ov_d  = 1'b0;
    end
  end

  // Stage-1 registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      s1_q   <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s1_q   <= s1_d;
    end
  end

  // Stage-2 (output) registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ov_q  <= 1'b0;
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      ov_q  <= ov_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid  = ov_q;
  assign out_res    = res_q;
  assign out_errcnt = cnt_q;

`ifdef CPRS_ERR_STAT_EN
  logic [31:0] beats_q;
  logic [31:0] beats_d;
  logic [31:0] errs_q;
  logic [31:0] errs_d;
  logic [32:0] errs_sum;
  logic        fire;

  assign fire     = ov_q & out_ready;
  assign errs_sum = {1'b0, errs_q} + 33'(cnt_q);

  // Saturating counters of delivered beats and their error counts.
  always_comb begin
    beats_d = beats_q;
    errs_d  = errs_q;
    if (fire) begin
      if (beats_q != '1) begin
        beats_d = beats_q + 32'd1;
      end
      errs_d = errs_sum[32] ? '1 : errs_sum[31:0];
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      beats_q <= '0;
      errs_q  <= '0;
    end else begin
      beats_q <= beats_d;
      errs_q  <= errs_d;
    end
  end

  assign stat_beats = beats_q;
  assign stat_errs  = errs_q;
`endif

endmodule

// File: tb/tb_cprs_err_recover.sv
// Randomized self-checking bench for cprs_err_recover (W=8),
// scored against a queue-based arithmetic reference model.
module tb_cprs_err_recover;

  localparam int W    = 8;
  localparam int ERRC = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_sum = '0;
  logic [W-1:0] in_carry = '0;
  logic [W-1:0] in_err = '0;
  logic         corr_en = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [10:0]  out_res;
  logic [3:0]   out_errcnt;
`ifdef CPRS_ERR_STAT_EN
  logic [31:0]  stat_beats;
  logic [31:0]  stat_errs;
`endif

  cprs_err_recover #(.W(W), .ERR_CORR(ERRC)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_carry   (in_carry),
    .in_err     (in_err),
    .corr_en    (corr_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_res    (out_res),
    .out_errcnt (out_errcnt)
`ifdef CPRS_ERR_STAT_EN
    ,
    .stat_beats (stat_beats),
    .stat_errs  (stat_errs)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic [W-1:0] c;
    logic [W-1:0] e;
    bit           ce;
    longint       er;
    int           ec;
  } beat_t;

  typedef struct {
    longint res;
    int     cnt;
    int     acyc;
  } exp_t;

  beat_t  pend[$];
  exp_t   expq[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc = 0;
  bit     lat_chk = 1'b0;
  logic   smp_ready;
  logic   smp_ovalid;
  logic [10:0] smp_res;
  longint st_beats = 0;
  longint st_errs = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic add_beat(input logic [W-1:0] s, input logic [W-1:0] c,
                          input logic [W-1:0] e, input bit ce,
                          input longint er, input int ec);
    beat_t b;
    b.s = s; b.c = c; b.e = e; b.ce = ce; b.er = er; b.ec = ec;
    pend.push_back(b);
  endtask

  // Reference: exact value = sum + 2*carry + ERR_CORR*err (if enabled).
  task automatic add_rand();
    logic [W-1:0] s, c, e;
    bit ce;
    longint er;
    s  = W'($urandom);
    c  = W'($urandom);
    e  = W'($urandom);
    ce = 1'($urandom);
    er = longint'(s) + 2 * longint'(c) + (ce ? ERRC * longint'(e) : 0);
    add_beat(s, c, e, ce, er, $countones(e));
  endtask

  task automatic step(input bit ordy, input bit gap);
    beat_t b;
    exp_t  x;
    bit    acc, drn;
    @(negedge clk);
    out_ready = ordy;
    if (pend.size() > 0 && !gap) begin
      b        = pend[0];
      in_valid = 1'b1;
      in_sum   = b.s;
      in_carry = b.c;
      in_err   = b.e;
      corr_en  = b.ce;
    end else begin
      in_valid = 1'b0;
      in_sum   = W'($urandom);
      in_carry = W'($urandom);
      in_err   = W'($urandom);
      corr_en  = 1'($urandom);
    end
    #1;
    acc        = in_valid & in_ready;
    drn        = out_valid & out_ready;
    smp_ready  = in_ready;
    smp_ovalid = out_valid;
    smp_res    = out_res;
    if (drn) begin
      if (expq.size() == 0) begin
        chk("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        x = expq.pop_front();
        chk("out_res", 64'(out_res), 64'(x.res));
        chk("out_errcnt", 64'(out_errcnt), 64'(x.cnt));
        if (lat_chk) chk("latency", 64'(cyc - x.acyc), 64'd2);
        st_beats++;
        st_errs += x.cnt;
      end
    end
    if (acc) begin
      void'(pend.pop_front());
      x.res  = b.er;
      x.cnt  = b.ec;
      x.acyc = cyc;
      expq.push_back(x);
    end
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((pend.size() + expq.size()) > 0 && n < budget) begin
      step(1'b1, 1'b0);
      n++;
    end
    chk("drain_left", 64'(pend.size() + expq.size()), 64'd0);
  endtask

  task automatic chk_stats(input string tag);
`ifdef CPRS_ERR_STAT_EN
    chk({tag, "_beats"}, 64'(stat_beats), 64'(st_beats));
    chk({tag, "_errs"}, 64'(stat_errs), 64'(st_errs));
`else
    if (tag.len() == 0) $display("no tag");
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    pend.delete();
    expq.delete();
    st_beats = 0;
    st_errs  = 0;
  endtask

  logic [10:0] held;

  initial begin
    // Reset state
    do_reset();
    chk("rst_ovalid", 64'(out_valid), 64'd0);
    chk("rst_res", 64'(out_res), 64'd0);
    chk("rst_cnt", 64'(out_errcnt), 64'd0);
    chk("rst_inrdy", 64'(in_ready), 64'd1);
    chk_stats("rst");

    // Directed corner values, latency 2
    lat_chk = 1'b1;
    add_beat(8'hFF, 8'h00, 8'h00, 1'b1, 255, 0);
    add_beat(8'h00, 8'h00, 8'hFF, 1'b1, 1020, 8);
    add_beat(8'h00, 8'h00, 8'hFF, 1'b0, 0, 8);
    add_beat(8'hFF, 8'hFF, 8'hFF, 1'b1, 1785, 8);
    add_beat(8'h01, 8'h01, 8'h01, 1'b1, 7, 1);
    drain(30);

    // 16 back-to-back random beats, one per cycle
    for (int i = 0; i < 16; i++) add_rand();
    drain(40);

    // Stall: 3 beats, out_ready low for 5 cycles
    lat_chk = 1'b0;
    for (int i = 0; i < 3; i++) add_rand();
    held = '0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      if (i >= 2) begin
        chk("stall_inrdy", 64'(smp_ready), 64'd0);
        chk("stall_ovalid", 64'(smp_ovalid), 64'd1);
      end
      if (i == 2) held = smp_res;
      if (i >= 3) chk("stall_hold", 64'(smp_res), 64'(held));
    end
    chk("stall_pend", 64'(pend.size()), 64'd1);
    drain(30);

    // Random traffic with gaps and backpressure
    for (int i = 0; i < 60; i++) add_rand();
    for (int n = 0; n < 1000 && (pend.size() + expq.size()) > 0; n++) begin
      step(($urandom % 4) != 0, ($urandom % 4) == 0);
    end
    chk("rand_left", 64'(pend.size() + expq.size()), 64'd0);
    step(1'b1, 1'b0);
    chk_stats("mid");

    // Reset with 2 beats in flight
    for (int i = 0; i < 2; i++) add_rand();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    do_reset();
    chk("mrst_ovalid", 64'(out_valid), 64'd0);
    chk("mrst_inrdy", 64'(in_ready), 64'd1);
    chk_stats("mrst");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      chk("mrst_nostale", 64'(smp_ovalid), 64'd0);
    end

    // Traffic after reset
    lat_chk = 1'b1;
    for (int i = 0; i < 6; i++) add_rand();
    drain(30);
    step(1'b1, 1'b0);
    chk_stats("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
